// File: rtl/cache_victim_sequencer_if.sv
// Interface between the cache FSM, the replacement unit, the bus beat interface and the
// victim sequencer. The sequencer connects through the slave modport. The environment
// (cache FSM, replacement unit and bus) connects through the master modport.
interface cache_victim_sequencer_if #(
    parameter int unsigned NUMWAYS      = 4,
    parameter int unsigned BEATSPERLINE = 4,
    parameter int unsigned BEATLEN      = $clog2(BEATSPERLINE)
);
    // Miss request from the cache FSM and the replacement unit
    logic               Miss;
    logic               FlushStage;
    logic [NUMWAYS-1:0] VictimWay;
    logic               VictimDirty;
    // Bus beat handshake
    logic               BusAck;
    logic               BusReq;
    logic               BusWrite;
    logic [BEATLEN-1:0] BeatCount;
    // Array and pipeline control
    logic [NUMWAYS-1:0] SelWay;
    logic               ClearValid;
    logic               SetValid;
    logic               LRUWriteEn;
    logic               Stall;
    logic               Done;

    modport master (
        output Miss, FlushStage, VictimWay, VictimDirty, BusAck,
        input  BusReq, BusWrite, BeatCount, SelWay, ClearValid, SetValid, LRUWriteEn,
               Stall, Done
    );

    modport slave (
        input  Miss, FlushStage, VictimWay, VictimDirty, BusAck,
        output BusReq, BusWrite, BeatCount, SelWay, ClearValid, SetValid, LRUWriteEn,
               Stall, Done
    );
endinterface

// File: rtl/cache_victim_sequencer.sv
// Victim eviction sequencer: on an accepted miss it latches the victim way, writes back a
// dirty victim over the bus, fetches the new line, then pulses the valid/LRU commit.
// Optional feature macro CACHE_SEQ_PERFCNT_EN adds writeback and fetch event counters.
module cache_victim_sequencer #(
    parameter int unsigned NUMWAYS      = 4,
    parameter int unsigned BEATSPERLINE = 4,
    parameter int unsigned BEATLEN      = $clog2(BEATSPERLINE)
) (
    input  logic                         clk,
    input  logic                         reset,
    cache_victim_sequencer_if.slave      bus
`ifdef CACHE_SEQ_PERFCNT_EN
    ,
    output logic [31:0]                  WritebackCnt,
    output logic [31:0]                  FetchCnt
`endif
);

    typedef enum logic [1:0] {StIdle, StEvict, StFetch, StCommit} state_e;

    state_e             state_q;
    logic [BEATLEN-1:0] beat_q;
    logic [NUMWAYS-1:0] selway_q;
    logic               busreq_q;
    logic               buswrite_q;
    logic               commit_q;

    logic               accept;
    logic               last_beat;

    // Acceptance and last-beat decode
    always_comb begin
        accept    = (state_q == StIdle) & bus.Miss & ~bus.FlushStage;
        last_beat = bus.BusAck & (beat_q == BEATLEN'(BEATSPERLINE - 1));
    end

    // Sequencer FSM; bus and commit outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            selway_q   <= '0;
            busreq_q   <= 1'b0;
            buswrite_q <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        selway_q <= bus.VictimWay;
                        beat_q   <= '0;
                        busreq_q <= 1'b1;
                        if (bus.VictimDirty) begin
                            state_q    <= StEvict;
                            buswrite_q <= 1'b1;
                        end else begin
                            state_q    <= StFetch;
                            buswrite_q <= 1'b0;
                        end
                    end
                end
                StEvict: begin
                    if (bus.BusAck) begin
                        if (last_beat) begin
                            beat_q     <= '0;
                            state_q    <= StFetch;
                            buswrite_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + BEATLEN'(1);
                        end
                    end
                end
                StFetch: begin
                    if (bus.BusAck) begin
                        if (last_beat) begin
                            beat_q   <= '0;
                            state_q  <= StCommit;
                            busreq_q <= 1'b0;
                            commit_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + BEATLEN'(1);
                        end
                    end
                end
                StCommit: begin
                    state_q  <= StIdle;
                    commit_q <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    busreq_q   <= 1'b0;
                    buswrite_q <= 1'b0;
                    commit_q   <= 1'b0;
                end
            endcase
        end
    end

    // Output drive; ClearValid and the accept part of Stall must act in the accept cycle
    assign bus.BusReq     = busreq_q;
    assign bus.BusWrite   = buswrite_q;
    assign bus.BeatCount  = beat_q;
    assign bus.SelWay     = selway_q;
    assign bus.ClearValid = accept;
    assign bus.SetValid   = commit_q;
    assign bus.LRUWriteEn = commit_q;
    assign bus.Done       = commit_q;
    assign bus.Stall      = (state_q != StIdle) | accept;

`ifdef CACHE_SEQ_PERFCNT_EN
    logic [31:0] wbcnt_q;
    logic [31:0] fetchcnt_q;

    // Event counters: completed writebacks and completed fetches
    always_ff @(posedge clk) begin
        if (reset) begin
            wbcnt_q    <= '0;
            fetchcnt_q <= '0;
        end else begin
            if ((state_q == StEvict) && last_beat) begin
                wbcnt_q <= wbcnt_q + 32'd1;
            end
            if ((state_q == StFetch) && last_beat) begin
                fetchcnt_q <= fetchcnt_q + 32'd1;
            end
        end
    end

    assign WritebackCnt = wbcnt_q;
    assign FetchCnt     = fetchcnt_q;
`endif

`ifndef SYNTHESIS
    // The producer must hand over a one-hot victim; a bad value is passed through untouched
    victim_onehot_a : assert property (@(posedge clk) disable iff (reset)
        accept |-> $onehot(bus.VictimWay))
        else $error("victim way not one-hot: %b", bus.VictimWay);
`endif

endmodule

// File: doc/cache_victim_sequencer.md
Name: cache_victim_sequencer

Overview:
- Consumer side of the replacement-policy interface.
- Takes the one-hot victim way chosen on a cache miss and sequences the eviction: writeback of a dirty victim over the bus, fetch of the new line, then the commit pulses (SetValid, LRUWriteEn) that update the valid and replacement state.
- Sits between the cache FSM/replacement unit and the bus beat interface, one instance per cache.

Parameters:
- NUMWAYS, 4, ways per set; power of 2, 2..128.
- BEATSPERLINE, 4, bus beats per line; power of 2, >=2.
- BEATLEN, $clog2(BEATSPERLINE), width of the beat counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- Miss  in  1  miss pending for current set; level, sampled in IDLE only.
- FlushStage  in  1  pipeline flush; blocks acceptance in IDLE.
- VictimWay  in  NUMWAYS  one-hot victim from replacement unit; valid while Miss.
- VictimDirty  in  1  dirty bit of the victim line; valid while Miss.
- BusAck  in  1  bus accepted/returned one beat this cycle.
- BusReq  out  1  bus transaction active.
- BusWrite  out  1  1 = writeback beats, 0 = fetch beats.
- BeatCount  out  BEATLEN  index of the current beat.
- SelWay  out  NUMWAYS  latched victim way, drives data/tag array way enables.
- ClearValid  out  1  invalidate the victim line.
- SetValid  out  1  mark the new line valid in SelWay.
- LRUWriteEn  out  1  update replacement state.
- Stall  out  1  hold the pipeline.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, EVICT, FETCH, COMMIT. Reset state is IDLE.
- Reset values: BeatCount=0 and SelWay=0. All other outputs are 0 in IDLE without an accepted Miss.
- Accept condition: state IDLE and Miss and ~FlushStage.
  - In the accept cycle: SelWay <= VictimWay, BeatCount <= 0, ClearValid=1 (combinational), Stall=1.
  - Next state is EVICT if VictimDirty, else FETCH.
- Miss with FlushStage in IDLE: not accepted, no outputs asserted, state stays IDLE.
- EVICT: BusReq=1, BusWrite=1.
  - Each cycle with BusAck, BeatCount increments.
  - On BusAck with BeatCount==BEATSPERLINE-1: BeatCount wraps to 0, next state FETCH.
- FETCH: BusReq=1, BusWrite=0.
  - Beat counting is identical to EVICT.
  - Last acknowledged beat goes to COMMIT.
- COMMIT: one cycle. SetValid=1, LRUWriteEn=1, Done=1, Stall=1. Next state IDLE.
- Cycles without BusAck hold BeatCount and state; there is no timeout.
- Stall = (state!=IDLE) | accept.
- In IDLE, Stall may drop in the cycle after Done, so a new Miss can be accepted there with zero bubble.
- Miss, FlushStage, VictimWay and VictimDirty are ignored outside IDLE. FlushStage never aborts a started line, because a bus transaction cannot be cancelled.
- SelWay holds its value from acceptance until the next acceptance.
- Latency with no bus wait states:
  - clean miss: 1 (accept) + BEATSPERLINE + 1 cycles;
  - dirty miss: 1 (accept) + 2*BEATSPERLINE + 1 cycles.
- Reset in any state: IDLE next cycle, BeatCount=0, SelWay=0. No SetValid/LRUWriteEn is issued for the aborted line.
- A non-one-hot VictimWay is passed through unchanged. Checking it is the producer's responsibility; the sim-only assertion covers it.

Optional Feature:
- CACHE_SEQ_PERFCNT_EN. When defined, adds two outputs:
  - WritebackCnt [31:0]: increments when EVICT goes to FETCH.
  - FetchCnt [31:0]: increments on entry to COMMIT.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan (NUMWAYS=4, BEATSPERLINE=4):
- Clean miss: Miss=1, VictimWay=4'b0100, VictimDirty=0, BusAck tied 1 -> ClearValid in cycle 0; FETCH with BeatCount 0..3 in cycles 1-4; COMMIT in cycle 5 with SetValid=LRUWriteEn=Done=1 and SelWay=4'b0100; Stall=0 in cycle 6.
- Dirty miss: VictimWay=4'b0001, VictimDirty=1, BusAck=1 -> EVICT with BusWrite=1 in cycles 1-4, FETCH with BusWrite=0 in cycles 5-8, Done in cycle 9.
- Wait states: clean miss, BusAck=0 on beats 1 and 2 for 3 cycles each -> BeatCount holds at 1 then 2; Done occurs 6 cycles later than the zero-wait case.
- Flush: Miss=1 with FlushStage=1 for 3 cycles -> Stall=0, ClearValid=0, BusReq=0. Drop FlushStage -> accepted the same cycle.
- Reset mid-op: dirty miss, assert reset while BeatCount==2 in EVICT -> next cycle IDLE, BusReq=0, SelWay=0; no SetValid is ever pulsed.
- Back-to-back: Miss held high through two misses -> second acceptance in the cycle after Done, with SelWay updated to the new VictimWay. With CACHE_SEQ_PERFCNT_EN defined, FetchCnt=2 afterwards.
